// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM state encoding for the bit-serial arithmetic blocks
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Borrow_in,
    output logic Diff,
    output logic Borrow_out
);

    logic w_x;
    logic w_gen;
    logic w_prop;

    // Same two-XOR / two-AND / one-OR shape as the adder cell, with inverted AND inputs.
    assign w_x        = A ^ B;
    assign Diff       = w_x ^ Borrow_in;
    assign w_gen      = ~A & B;
    assign w_prop     = ~w_x & Borrow_in;
    assign Borrow_out = w_gen | w_prop;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor; SERIAL_SUB_OVERFLOW_EN adds signed overflow
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Borrow_in,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow_out,
    output logic             Overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               w_d;
    logic               w_c;
    logic               w_accept;
    logic               w_shift;
    logic               w_last;

    full_subtractor u_fs (
        .A          (r_a_sh[0]),
        .B          (r_b_sh[0]),
        .Borrow_in  (r_borrow),
        .Diff       (w_d),
        .Borrow_out (w_c)
    );

    assign w_accept = (r_state == S_IDLE) && In_valid;
    assign w_shift  = (r_state == S_SHIFT);
    assign w_last   = w_shift && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (In_valid)  w_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_next = S_DONE;
            S_DONE:  if (Out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // In_ready is gated by reset so it reads 0 for the whole time reset is held.
    assign In_ready  = Rst_n && (r_state == S_IDLE);
    assign Out_valid = (r_state == S_DONE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_borrow <= Borrow_in;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_borrow <= w_c;
            r_res    <= (WIDTH-1)'({w_d, r_res} >> 1);
            r_cnt    <= r_cnt + CNT_W'(1);
            // Result is published only at DONE entry so outputs stay put while shifting.
            if (w_last) begin
                r_diff <= {w_d, r_res};
                r_bout <= w_c;
            end
        end
    end

    assign Difference = r_diff;
    assign Borrow_out = r_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // On the last step w_d is the result MSB.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end else if (w_last) begin
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign Overflow = r_ovf;
`else
    assign Overflow = 1'b0;
`endif

endmodule
